// File: rtl/skinny_sbox8_dom1_layer_ctrl.sv
// SKINNY-128 S-box layer sequencer for a 2-share (DOM1) masked state.
// Feeds one byte at a time through a shared, non-pipelined external sbox8.
// The sbox inputs and the refresh mask stay constant for HOLD+1 cycles.
// The masked result is then written back into the working share registers.
module skinny_sbox8_dom1_layer_ctrl #(
    parameter int NBYTES = 16,
    parameter int HOLD   = 2,
    parameter int RW     = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   st0,
    input  logic [8*NBYTES-1:0]   st1,
    input  logic                  rnd_valid,
    output logic                  rnd_ready,
    input  logic [RW-1:0]         rnd,
    output logic [7:0]            sbox_si0,
    output logic [7:0]            sbox_si1,
    output logic [RW-1:0]         sbox_r,
    input  logic [7:0]            sbox_bo0,
    input  logic [7:0]            sbox_bo1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   so0,
    output logic [8*NBYTES-1:0]   so1,
    output logic                  busy
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_RND = 2'd1,
        S_EVAL     = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [7:0]          si0_q, si0_d;
    logic [7:0]          si1_q, si1_d;
    logic [RW-1:0]       r_q, r_d;
    logic [8*NBYTES-1:0] so0_q, so0_d;
    logic [8*NBYTES-1:0] so1_q, so1_d;

    logic last_byte;
    logic eval_end;

    assign last_byte = (idx_q == IW'(NBYTES - 1));
    assign eval_end  = (cnt_q == CW'(HOLD));

    // State and datapath registers; reset aborts any layer in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            si0_q   <= '0;
            si1_q   <= '0;
            r_q     <= '0;
            so0_q   <= '0;
            so1_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            si0_q   <= si0_d;
            si1_q   <= si1_d;
            r_q     <= r_d;
            so0_q   <= so0_d;
            so1_q   <= so1_d;
        end
    end

    // Next-state logic: accept, fetch mask, evaluate for HOLD+1 cycles, present.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (in_valid)  state_d = S_WAIT_RND;
            S_WAIT_RND: if (rnd_valid) state_d = S_EVAL;
            S_EVAL:     if (eval_end)  state_d = last_byte ? S_DONE : S_WAIT_RND;
            S_DONE:     if (out_ready) state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    // Datapath: each share is handled separately; the two shares never meet here.
    always_comb begin
        idx_d = idx_q;
        cnt_d = cnt_q;
        si0_d = si0_q;
        si1_d = si1_q;
        r_d   = r_q;
        so0_d = so0_q;
        so1_d = so1_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    so0_d = st0;
                    so1_d = st1;
                    idx_d = '0;
                end
            end
            S_WAIT_RND: begin
                if (rnd_valid) begin
                    si0_d = so0_q[8*idx_q +: 8];
                    si1_d = so1_q[8*idx_q +: 8];
                    r_d   = rnd;
                    cnt_d = '0;
                end
            end
            S_EVAL: begin
                cnt_d = cnt_q + 1'b1;
                if (eval_end) begin
                    // sbox outputs are settled; write back in place
                    so0_d[8*idx_q +: 8] = sbox_bo0;
                    so1_d[8*idx_q +: 8] = sbox_bo1;
                    cnt_d               = '0;
                    if (!last_byte) idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Handshake outputs are pure decodes of the state.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        rnd_ready = (state_q == S_WAIT_RND);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

    assign sbox_si0 = si0_q;
    assign sbox_si1 = si1_q;
    assign sbox_r   = r_q;
    assign so0      = so0_q;
    assign so1      = so1_q;

endmodule

// File: tb/tb_skinny_sbox8_dom1_layer_ctrl.sv
// Scoreboard bench: the driver pushes the expected unmasked layer output per
// accepted state, and a negedge monitor pops and compares when out_valid rises.
// A behavioural 2-cycle sbox8 model (DOM-style output split) sits on the sbox port.
module tb_skinny_sbox8_dom1_layer_ctrl;
    localparam int NB = 16;
    localparam int RW = 25;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [8*NB-1:0] st0 = '0, st1 = '0;
    logic            rnd_valid = 1'b0;
    logic            rnd_ready;
    logic [RW-1:0]   rnd = '0;
    logic [7:0]      sbox_si0, sbox_si1, sbox_bo0, sbox_bo1;
    logic [RW-1:0]   sbox_r;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [8*NB-1:0] so0, so1;
    logic            busy;

    always #5 clk = ~clk;

    skinny_sbox8_dom1_layer_ctrl #(.NBYTES(NB), .HOLD(2), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .st0(st0), .st1(st1),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
        .sbox_si0(sbox_si0), .sbox_si1(sbox_si1), .sbox_r(sbox_r),
        .sbox_bo0(sbox_bo0), .sbox_bo1(sbox_bo1),
        .out_valid(out_valid), .out_ready(out_ready), .so0(so0), .so1(so1),
        .busy(busy)
    );

    // SKINNY-128 8-bit S-box from its round-function definition.
    function automatic logic [7:0] skinny_s8(input logic [7:0] x);
        logic [7:0] y;
        y = x;
        for (int k = 0; k < 4; k++) begin
            y = y ^ (~(((y >> 1) | y) >> 2) & 8'h11);
            if (k < 3)
                y = ((y & 8'h01) << 2) | ((y & 8'h06) << 5) | ((y & 8'h20) >> 5)
                  | ((y & 8'hC8) >> 2) | ((y & 8'h10) >> 1);
        end
        return (y & 8'hF9) | ((y >> 1) & 8'h02) | ((y << 1) & 8'h04);
    endfunction

    function automatic logic [8*NB-1:0] layer(input logic [8*NB-1:0] x);
        logic [8*NB-1:0] y;
        for (int i = 0; i < NB; i++) y[8*i +: 8] = skinny_s8(x[8*i +: 8]);
        return y;
    endfunction

    function automatic logic [7:0] share0_of(input logic [RW-1:0] r);
        return r[7:0] ^ r[24:17];
    endfunction

    function automatic logic [8*NB-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // External sbox model: outputs reflect the inputs two edges after they change.
    logic [15:0] sb_s1 = '0, sb_s2 = '0;
    always @(posedge clk) begin
        sb_s1 <= {skinny_s8(sbox_si0 ^ sbox_si1) ^ share0_of(sbox_r), share0_of(sbox_r)};
        sb_s2 <= sb_s1;
    end
    assign sbox_bo1 = sb_s2[15:8];
    assign sbox_bo0 = sb_s2[7:0];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, acc_cyc = 0, hs_run = 0, since = 3, stall_left = 0, exp_lat = -1;
    bit stall_en = 0, rand_rv = 0, hs_pend = 0, acc_pend = 0, ov_prev = 0, odone_prev = 0;
    logic [RW-1:0]   last_r = '0;
    logic [RW-1:0]   rw [NB];
    logic [8*NB-1:0] cur0 = '0, cur1 = '0, last_res = '0, last_so0 = '0;
    logic [8*NB-1:0] sbq [$];
    logic [255:0]    held = '0;

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Edge bookkeeping: handshakes seen at the previous negedge, mask words, stall.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            hs_run = 0; since = 3; stall_left = 0;
        end else begin
            if (acc_pend) begin hs_run = 0; since = 3; acc_cyc = cyc; end
            if (hs_pend) begin
                if (hs_run < NB) rw[hs_run] = rnd;
                last_r = rnd;
                hs_run++;
                since = 0;
                if (stall_en && hs_run == 3) stall_left = 8;
            end else begin
                if (since < 3) since++;
                if (stall_left > 0) stall_left--;
            end
        end
        #1;
        rnd = RW'($urandom);
        rnd_valid = rand_rv ? 1'($urandom_range(0, 1)) : (stall_left == 0);
    end

    // Monitor: hold checks every cycle, scoreboard pop when out_valid rises.
    always @(negedge clk) begin
        logic [8*NB-1:0] exp_res, exp0;
        hs_pend  = rnd_valid && rnd_ready && !rst;
        acc_pend = in_valid && in_ready && !rst;
        if (!rst) begin
            if (busy && !out_valid && hs_run > 0)
                chk("sbox_hold", {sbox_si0, sbox_si1, sbox_r, (since < 3) && rnd_ready},
                    {cur0[8*(hs_run-1) +: 8], cur1[8*(hs_run-1) +: 8], last_r, 1'b0});
            if (out_valid && !ov_prev) begin
                for (int i = 0; i < NB; i++) exp0[8*i +: 8] = share0_of(rw[i]);
                if (sbq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL scoreboard: out_valid with no expected entry, required none");
                end else begin
                    exp_res = sbq.pop_front();
                    chk("result_unmasked", so0 ^ so1, exp_res);
                    chk("result_share0", so0, exp0);
                end
                chk("rnd_handshakes", 320'(hs_run), 320'(NB));
                if (exp_lat >= 0) chk("latency", 320'(cyc - acc_cyc), 320'(exp_lat));
                held     = {so0, so1};
                last_res = so0 ^ so1;
                last_so0 = so0;
            end else if (out_valid) begin
                chk("done_stable", {so0, so1, in_ready, rnd_ready}, {held, 2'b00});
            end
            if (odone_prev) chk("back_to_idle", {out_valid, in_ready, busy}, 3'b010);
        end
        ov_prev    = out_valid && !rst;
        odone_prev = out_valid && out_ready && !rst;
    end

    task automatic check_reset(input string nm);
        chk({nm, "_ctrl"}, {in_ready, rnd_ready, out_valid, busy, sbox_si0, sbox_si1, sbox_r},
            {4'b1000, 41'd0});
        chk({nm, "_shares"}, {so0, so1}, 320'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sbq.delete();
    endtask

    task automatic issue(input logic [8*NB-1:0] a, input logic [8*NB-1:0] b, input int lat,
                         input bit stall);
        cur0 = a; cur1 = b; exp_lat = lat; stall_en = stall;
        sbq.push_back(layer(a ^ b));
        st0 = a; st1 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        st0 = rand128(); st1 = rand128();
    endtask

    task automatic run(input logic [8*NB-1:0] a, input logic [8*NB-1:0] b, input int lat,
                       input int ordly, input bit stall, input bit junk);
        int t;
        issue(a, b, lat, stall);
        t = 0;
        while (!out_valid && t < 600) begin
            @(posedge clk); #1;
            t++;
            if (junk) in_valid = (t >= 10 && t < 20);
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            n_chk++; n_fail++;
            $display("FAIL timeout: out_valid low after %0d cycles, required high", t);
            pulse_reset();
            return;
        end
        repeat (ordly) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [8*NB-1:0] a, p;
        int t;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("reset_idle");

        run('0, '0, 64, 0, 0, 0);
        chk("layer_00", 320'(last_res), 320'({16{8'h65}}));

        a = rand128();
        run(a, a ^ {16{8'h01}}, 64, 2, 0, 0);
        chk("layer_01", 320'(last_res), 320'({16{8'h4C}}));
        p = last_so0;
        run(a, a ^ {16{8'h01}}, 64, 0, 0, 0);
        n_chk++;
        if (last_so0 === p) begin
            n_fail++;
            $display("FAIL share0_fresh: so0 %h repeated across runs, required different", last_so0);
        end

        a = rand128();
        run(a, a ^ {16{8'hFF}}, 64, 0, 0, 0);
        chk("layer_ff", 320'(last_res), 320'({16{8'hFF}}));

        run(rand128(), rand128(), 69, 0, 1, 0);

        issue(rand128(), rand128(), -1, 0);
        t = 0;
        while (!(hs_run == 8 && since == 1) && t < 200) begin @(posedge clk); #1; t++; end
        pulse_reset();
        @(negedge clk);
        check_reset("reset_mid");

        run(rand128(), rand128(), 64, 10, 0, 1);

        rand_rv = 1;
        repeat (4) run(rand128(), rand128(), -1, $urandom_range(0, 3), 0, 0);
        rand_rv = 0;

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
